// File: rtl/iob_bus_arbiter_if.sv
// Single IOb-style bus port: request strobe + payload one way, one-cycle ready + read data back.
// master drives the request, slave answers it.
interface iob_bus_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  valid;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic [DATA_W-1:0]     rdata;
   logic                  ready;

   modport master (output valid, addr, wdata, wstrb, input rdata, ready);
   modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_bus_arbiter.sv
// Two-master to one-slave bus arbiter with a latched request and an IDLE/BUSY FSM.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed m0 priority.
module iob_bus_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   iob_bus_arbiter_if.slave     m0,
   iob_bus_arbiter_if.slave     m1,
   iob_bus_arbiter_if.master    s,
   output logic                 grant,
   output logic                 busy
);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e                state_q, state_d;
   logic                  grant_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   wstrb_q;
   logic                  sel;
   logic                  start;
   logic                  done;

   assign start = (state_q == StIdle) && (m0.valid || m1.valid);
   assign done  = (state_q == StBusy) && s.ready;

`ifdef ARB_ROUND_ROBIN_EN
   logic ptr_q;

   // Pointer names the master to favour on a tie: the one not served last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else if (done) begin
         ptr_q <= ~grant_q;
      end
   end

   always_comb begin
      sel = m1.valid;
      if (m0.valid && m1.valid) begin
         sel = ptr_q;
      end
   end
`else
   always_comb begin
      sel = ~m0.valid;
   end
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StBusy;
         StBusy:  if (s.ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Request latch: the slave sees a frozen copy, immune to master-side changes while BUSY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else if (start) begin
         grant_q <= sel;
         addr_q  <= sel ? m1.addr  : m0.addr;
         wdata_q <= sel ? m1.wdata : m0.wdata;
         wstrb_q <= sel ? m1.wstrb : m0.wstrb;
      end
   end

   // Outputs
   always_comb begin
      busy     = (state_q == StBusy);
      grant    = grant_q;
      s.valid  = (state_q == StBusy);
      s.addr   = addr_q;
      s.wdata  = wdata_q;
      s.wstrb  = wstrb_q;
      m0.ready = done && !grant_q;
      m1.ready = done && grant_q;
      m0.rdata = '0;
      m1.rdata = '0;
      if (done && !grant_q) m0.rdata = s.rdata;
      if (done && grant_q)  m1.rdata = s.rdata;
   end

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Self-checking bench for iob_bus_arbiter: scoreboard of expected transactions plus a slave model.
module tb_iob_bus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic grant;
   logic busy;
   int   total = 0;
   int   bad = 0;
   int   r0_cnt = 0;
   int   r1_cnt = 0;

   typedef struct {
      int          who;
      logic [31:0] rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_t;

   exp_t sb[$];

   iob_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
   iob_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
   iob_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

   iob_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .m0    (m0_bus),
      .m1    (m1_bus),
      .s     (s_bus),
      .grant (grant),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   // Count every ready pulse seen by each master.
   always @(negedge clk) begin
      #2;
      if (m0_bus.ready === 1'b1) r0_cnt++;
      if (m1_bus.ready === 1'b1) r1_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   // Slave model: waits for s_valid (bounded), answers lat cycles later, captures what it saw.
   task automatic serve(input int lat, input logic [31:0] rd, input bit keep, input bit mutate,
                        output int wait_cyc, output logic [31:0] a0, output logic [31:0] w0,
                        output logic [3:0] st0, output logic g0, output logic [31:0] a_end,
                        output int who, output logic [31:0] got_rd, output logic [31:0] other_rd);
      wait_cyc = 0;
      #1;
      while (s_bus.valid !== 1'b1 && wait_cyc < 20) begin
         @(negedge clk);
         #1;
         wait_cyc++;
      end
      a0  = s_bus.addr;
      w0  = s_bus.wdata;
      st0 = s_bus.wstrb;
      g0  = grant;
      if (mutate) begin
         m0_bus.addr  = 32'h80;
         m0_bus.valid = 1'b0;
      end
      for (int i = 0; i < lat; i++) @(negedge clk);
      s_bus.ready = 1'b1;
      s_bus.rdata = rd;
      #1;
      a_end = s_bus.addr;
      if (m0_bus.ready === 1'b1 && m1_bus.ready === 1'b1) who = 2;
      else if (m0_bus.ready === 1'b1) who = 0;
      else if (m1_bus.ready === 1'b1) who = 1;
      else who = -1;
      got_rd   = (who == 1) ? m1_bus.rdata : m0_bus.rdata;
      other_rd = (who == 1) ? m0_bus.rdata : m1_bus.rdata;
      @(negedge clk);
      s_bus.ready = 1'b0;
      s_bus.rdata = '0;
      if (!keep) begin
         if (who == 0) m0_bus.valid = 1'b0;
         if (who == 1) m1_bus.valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      m0_bus.valid = 1'b1; m0_bus.addr = 32'h44; m0_bus.wdata = 32'h1; m0_bus.wstrb = 4'h3;
      m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
      s_bus.ready = 1'b0; s_bus.rdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total++; if (s_bus.valid !== 1'b0) begin bad++; $display("FAIL reset_s_valid got=%b want=0", s_bus.valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (grant !== 1'b0) begin bad++; $display("FAIL reset_grant got=%b want=0", grant); end
      total++; if (m0_bus.ready !== 1'b0 || m1_bus.ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready got=%b%b want=00", m0_bus.ready, m1_bus.ready);
      end
      total++; if (s_bus.addr !== 32'h0 || s_bus.wdata !== 32'h0 || s_bus.wstrb !== 4'h0) begin
         bad++; $display("FAIL reset_latch got=%h/%h/%h want=0/0/0", s_bus.addr, s_bus.wdata, s_bus.wstrb);
      end
      m0_bus.valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_read();
      int wc, who, c0, c1;
      logic [31:0] a0, w0, ae, grd, ord;
      logic [3:0] st0;
      logic g0;
      exp_t e;
      @(negedge clk);
      c0 = r0_cnt; c1 = r1_cnt;
      m0_bus.addr = 32'h100; m0_bus.wdata = '0; m0_bus.wstrb = 4'h0; m0_bus.valid = 1'b1;
      sb.push_back('{0, 32'hDEADBEEF, 32'h100, 32'h0, 4'h0});
      serve(3, 32'hDEADBEEF, 1'b0, 1'b0, wc, a0, w0, st0, g0, ae, who, grd, ord);
      e = sb.pop_front();
      total++; if (wc !== 1) begin bad++; $display("FAIL read_latency got=%0d want=1", wc); end
      total++; if (a0 !== e.addr) begin bad++; $display("FAIL read_addr got=%h want=%h", a0, e.addr); end
      total++; if (st0 !== e.wstrb) begin bad++; $display("FAIL read_wstrb got=%h want=%h", st0, e.wstrb); end
      total++; if (who !== e.who) begin bad++; $display("FAIL read_who got=%0d want=%0d", who, e.who); end
      total++; if (grd !== e.rd) begin bad++; $display("FAIL read_rdata got=%h want=%h", grd, e.rd); end
      total++; if (ord !== 32'h0) begin bad++; $display("FAIL read_other_rdata got=%h want=0", ord); end
      total++; if (r0_cnt - c0 !== 1 || r1_cnt - c1 !== 0) begin
         bad++; $display("FAIL read_pulses got=%0d/%0d want=1/0", r0_cnt - c0, r1_cnt - c1);
      end
   endtask

   task automatic test_write();
      int wc, who, c1;
      logic [31:0] a0, w0, ae, grd, ord;
      logic [3:0] st0;
      logic g0;
      exp_t e;
      @(negedge clk);
      c1 = r1_cnt;
      m1_bus.addr = 32'h20; m1_bus.wdata = 32'h12345678; m1_bus.wstrb = 4'hF; m1_bus.valid = 1'b1;
      sb.push_back('{1, 32'h0, 32'h20, 32'h12345678, 4'hF});
      serve(1, 32'h0, 1'b0, 1'b0, wc, a0, w0, st0, g0, ae, who, grd, ord);
      e = sb.pop_front();
      total++; if (a0 !== e.addr) begin bad++; $display("FAIL write_addr got=%h want=%h", a0, e.addr); end
      total++; if (w0 !== e.wdata) begin bad++; $display("FAIL write_wdata got=%h want=%h", w0, e.wdata); end
      total++; if (st0 !== e.wstrb) begin bad++; $display("FAIL write_wstrb got=%h want=%h", st0, e.wstrb); end
      total++; if (g0 !== 1'b1) begin bad++; $display("FAIL write_grant got=%b want=1", g0); end
      total++; if (who !== e.who) begin bad++; $display("FAIL write_who got=%0d want=%0d", who, e.who); end
      total++; if (r1_cnt - c1 !== 1) begin bad++; $display("FAIL write_pulses got=%0d want=1", r1_cnt - c1); end
   endtask

   task automatic test_back_to_back();
      int wc, who, exp_who;
      logic [31:0] a0, w0, ae, grd, ord;
      logic [3:0] st0;
      logic g0;
      exp_t e;
      @(negedge clk);
      m0_bus.addr = 32'h200; m0_bus.wdata = '0; m0_bus.wstrb = '0;
      m1_bus.addr = 32'h300; m1_bus.wdata = '0; m1_bus.wstrb = '0;
      m0_bus.valid = 1'b1; m1_bus.valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_who = i % 2;
`else
         exp_who = 0;
`endif
         sb.push_back('{exp_who, 32'hA0 + i, (exp_who == 1) ? 32'h300 : 32'h200, 32'h0, 4'h0});
      end
      for (int i = 0; i < 4; i++) begin
         serve(1, 32'hA0 + i, 1'b1, 1'b0, wc, a0, w0, st0, g0, ae, who, grd, ord);
         e = sb.pop_front();
         total++; if (g0 !== e.who[0]) begin bad++; $display("FAIL b2b_grant[%0d] got=%b want=%0d", i, g0, e.who); end
         total++; if (who !== e.who) begin bad++; $display("FAIL b2b_who[%0d] got=%0d want=%0d", i, who, e.who); end
         total++; if (a0 !== e.addr) begin bad++; $display("FAIL b2b_addr[%0d] got=%h want=%h", i, a0, e.addr); end
         total++; if (grd !== e.rd) begin bad++; $display("FAIL b2b_rdata[%0d] got=%h want=%h", i, grd, e.rd); end
      end
      m0_bus.valid = 1'b0; m1_bus.valid = 1'b0;
   endtask

   task automatic test_addr_change();
      int wc, who, c0;
      logic [31:0] a0, w0, ae, grd, ord;
      logic [3:0] st0;
      logic g0;
      exp_t e;
      @(negedge clk);
      c0 = r0_cnt;
      m0_bus.addr = 32'h40; m0_bus.wdata = 32'hCAFE; m0_bus.wstrb = 4'h1; m0_bus.valid = 1'b1;
      sb.push_back('{0, 32'h55, 32'h40, 32'hCAFE, 4'h1});
      serve(2, 32'h55, 1'b0, 1'b1, wc, a0, w0, st0, g0, ae, who, grd, ord);
      e = sb.pop_front();
      total++; if (a0 !== e.addr) begin bad++; $display("FAIL chg_addr_start got=%h want=%h", a0, e.addr); end
      total++; if (ae !== e.addr) begin bad++; $display("FAIL chg_addr_end got=%h want=%h", ae, e.addr); end
      total++; if (who !== e.who) begin bad++; $display("FAIL chg_who got=%0d want=%0d", who, e.who); end
      total++; if (grd !== e.rd) begin bad++; $display("FAIL chg_rdata got=%h want=%h", grd, e.rd); end
      total++; if (r0_cnt - c0 !== 1) begin bad++; $display("FAIL chg_pulses got=%0d want=1", r0_cnt - c0); end
   endtask

   task automatic test_reset_busy();
      int wc, who, c0, c1;
      logic [31:0] a0, w0, ae, grd, ord;
      logic [3:0] st0;
      logic g0;
      exp_t e;
      @(negedge clk);
      c0 = r0_cnt; c1 = r1_cnt;
      m1_bus.addr = 32'h60; m1_bus.wstrb = 4'h0; m1_bus.valid = 1'b1;
      @(negedge clk);
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstb_busy_before got=%b want=1", busy); end
      rst = 1'b1;
      #1;
      total++; if (s_bus.valid !== 1'b0) begin bad++; $display("FAIL rstb_s_valid got=%b want=0", s_bus.valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstb_busy got=%b want=0", busy); end
      total++; if (grant !== 1'b0) begin bad++; $display("FAIL rstb_grant got=%b want=0", grant); end
      m1_bus.valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (r0_cnt != c0 || r1_cnt != c1) begin
         bad++; $display("FAIL rstb_no_pulse got=%0d/%0d want=0/0", r0_cnt - c0, r1_cnt - c1);
      end
      m0_bus.addr = 32'h70; m0_bus.wstrb = 4'h0; m0_bus.valid = 1'b1;
      sb.push_back('{0, 32'h77, 32'h70, 32'h0, 4'h0});
      serve(2, 32'h77, 1'b0, 1'b0, wc, a0, w0, st0, g0, ae, who, grd, ord);
      e = sb.pop_front();
      total++; if (wc !== 1) begin bad++; $display("FAIL rstb_next_latency got=%0d want=1", wc); end
      total++; if (a0 !== e.addr) begin bad++; $display("FAIL rstb_next_addr got=%h want=%h", a0, e.addr); end
      total++; if (who !== e.who || grd !== e.rd) begin
         bad++; $display("FAIL rstb_next_resp got=%0d/%h want=%0d/%h", who, grd, e.who, e.rd);
      end
   endtask

   task automatic test_idle_ready();
      int c0, c1;
      @(negedge clk);
      c0 = r0_cnt; c1 = r1_cnt;
      s_bus.ready = 1'b1; s_bus.rdata = 32'hFFFF_0000;
      #1;
      total++; if (m0_bus.ready !== 1'b0 || m1_bus.ready !== 1'b0) begin
         bad++; $display("FAIL idle_ready got=%b%b want=00", m0_bus.ready, m1_bus.ready);
      end
      total++; if (m0_bus.rdata !== 32'h0 || m1_bus.rdata !== 32'h0) begin
         bad++; $display("FAIL idle_rdata got=%h/%h want=0/0", m0_bus.rdata, m1_bus.rdata);
      end
      @(negedge clk);
      s_bus.ready = 1'b0; s_bus.rdata = '0;
      #1;
      total++; if (busy !== 1'b0 || s_bus.valid !== 1'b0) begin
         bad++; $display("FAIL idle_state got=%b/%b want=0/0", busy, s_bus.valid);
      end
      @(negedge clk);
      total++; if (r0_cnt != c0 || r1_cnt != c1) begin
         bad++; $display("FAIL idle_pulses got=%0d/%0d want=0/0", r0_cnt - c0, r1_cnt - c1);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_addr_change();
      test_reset_busy();
      test_idle_ready();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
